// File: rtl/parking_pkg.sv
// Shared parking-lot definitions: lane FSM state encoding and default clock rate.
package parking_pkg;

    localparam int CLK_FREQ_HZ_DEFAULT = 100_000_000;

    // Numeric codes are also decoded by the debug display, so keep them fixed.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_IN_A     = 3'd1;
    localparam logic [2:0] ST_IN_AB    = 3'd2;
    localparam logic [2:0] ST_IN_B     = 3'd3;
    localparam logic [2:0] ST_OUT_B    = 3'd4;
    localparam logic [2:0] ST_OUT_BA   = 3'd5;
    localparam logic [2:0] ST_OUT_A    = 3'd6;
    localparam logic [2:0] ST_WAIT_CLR = 3'd7;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        IN_A     = ST_IN_A,
        IN_AB    = ST_IN_AB,
        IN_B     = ST_IN_B,
        OUT_B    = ST_OUT_B,
        OUT_BA   = ST_OUT_BA,
        OUT_A    = ST_OUT_A,
        WAIT_CLR = ST_WAIT_CLR
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lane_direction_detect.sv
// Two-beam lane sequencer: emits entry_pulse / exit_pulse on completed passages.
// Optional per-step stall timeout compiled in with `define LANE_DIR_TIMEOUT_EN.
module lane_direction_detect
    import parking_pkg::*;
#(
    parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int TIMEOUT_MS  = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic beam_outer,
    input  logic beam_inner,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic busy,
    output logic fault
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;

    logic       o_sync, i_sync;
    logic [1:0] s;
    state_t     state, state_next;
    logic       entry_next, exit_next;
    logic       timeout_hit;

    sync_2ff u_sync_outer (.clk(clk), .rst(rst), .d(beam_outer), .q(o_sync));
    sync_2ff u_sync_inner (.clk(clk), .rst(rst), .d(beam_inner), .q(i_sync));

    assign s = {o_sync, i_sync};

`ifdef LANE_DIR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    // Measures how long the current sequence step has persisted.
    always_ff @(posedge clk) begin
        if (rst || (state_next != state) || (state == IDLE) || (state == WAIT_CLR))
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout_hit = (state != IDLE) && (state != WAIT_CLR) &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        entry_next = 1'b0;
        exit_next  = 1'b0;
        case (state)
            IDLE: case (s)
                2'b10:   state_next = IN_A;
                2'b01:   state_next = OUT_B;
                2'b11:   state_next = WAIT_CLR;
                default: state_next = IDLE;
            endcase
            IN_A: case (s)
                2'b11:   state_next = IN_AB;
                2'b00:   state_next = IDLE;
                2'b01:   state_next = WAIT_CLR;
                default: state_next = IN_A;
            endcase
            IN_AB: case (s)
                2'b01:   state_next = IN_B;
                2'b10:   state_next = IN_A;
                2'b00:   state_next = WAIT_CLR;
                default: state_next = IN_AB;
            endcase
            IN_B: case (s)
                2'b00: begin
                    state_next = IDLE;
                    entry_next = 1'b1;
                end
                2'b11:   state_next = IN_AB;
                2'b10:   state_next = WAIT_CLR;
                default: state_next = IN_B;
            endcase
            OUT_B: case (s)
                2'b11:   state_next = OUT_BA;
                2'b00:   state_next = IDLE;
                2'b10:   state_next = WAIT_CLR;
                default: state_next = OUT_B;
            endcase
            OUT_BA: case (s)
                2'b10:   state_next = OUT_A;
                2'b01:   state_next = OUT_B;
                2'b00:   state_next = WAIT_CLR;
                default: state_next = OUT_BA;
            endcase
            OUT_A: case (s)
                2'b00: begin
                    state_next = IDLE;
                    exit_next  = 1'b1;
                end
                2'b11:   state_next = OUT_BA;
                2'b01:   state_next = WAIT_CLR;
                default: state_next = OUT_A;
            endcase
            WAIT_CLR: begin
                if (s == 2'b00) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A stalled step aborts even if the same sample would have completed it.
        if (timeout_hit) begin
            state_next = WAIT_CLR;
            entry_next = 1'b0;
            exit_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
        end else begin
            state       <= state_next;
            entry_pulse <= entry_next;
            exit_pulse  <= exit_next;
        end
    end

    assign busy  = (state != IDLE);
    assign fault = (state == WAIT_CLR);

endmodule

// File: tb/tb_lane_direction_detect.sv
// Randomized and directed checks of lane_direction_detect against a path-walk reference model.
module tb_lane_direction_detect;

    localparam int TC = 10;
`ifdef LANE_DIR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic beam_outer = 1'b0;
    logic beam_inner = 1'b0;
    logic entry_pulse, exit_pulse, busy, fault;

    int total = 0;
    int bad   = 0;

    // Model: dir 0=idle, 1=entering, 2=exiting, 3=waiting for clear; pos = step along the path.
    logic [1:0] m_d1 = 2'b00, m_d2 = 2'b00;
    int   m_dir = 0, m_pos = 0, m_age = 0;
    logic m_entry = 1'b0, m_exit = 1'b0;

    logic [3:0] obs_q[$];
    logic [3:0] exp_q[$];

    lane_direction_detect #(.CLK_FREQ_HZ(1000), .TIMEOUT_MS(10)) dut (
        .clk(clk), .rst(rst), .beam_outer(beam_outer), .beam_inner(beam_inner),
        .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [1:0] sv);
        logic [1:0] p[3];
        int pdir, ppos;
        pdir = m_dir;
        ppos = m_pos;
        m_entry = 1'b0;
        m_exit  = 1'b0;
        if (m_dir == 1) p = '{2'b10, 2'b11, 2'b01};
        else            p = '{2'b01, 2'b11, 2'b10};
        if ((m_dir == 1 || m_dir == 2) && TO_EN && m_age >= TC - 1) begin
            m_dir = 3;
        end else if (m_dir == 0) begin
            if (sv == 2'b10)      begin m_dir = 1; m_pos = 0; end
            else if (sv == 2'b01) begin m_dir = 2; m_pos = 0; end
            else if (sv == 2'b11) m_dir = 3;
        end else if (m_dir == 3) begin
            if (sv == 2'b00) m_dir = 0;
        end else begin
            if (sv == p[m_pos]) begin
            end else if (m_pos < 2 && sv == p[m_pos+1]) m_pos++;
            else if (m_pos > 0 && sv == p[m_pos-1]) m_pos--;
            else if (sv == 2'b00 && m_pos == 0) m_dir = 0;
            else if (sv == 2'b00 && m_pos == 2) begin
                if (m_dir == 1) m_entry = 1'b1;
                else            m_exit  = 1'b1;
                m_dir = 0;
            end else m_dir = 3;
        end
        if (m_dir != pdir || m_pos != ppos || m_dir == 0 || m_dir == 3) m_age = 0;
        else m_age++;
    endtask

    // One clock: apply beams, advance the model at the edge, record DUT vs model at negedge.
    task automatic tick(input logic [1:0] v);
        logic [1:0] sv;
        beam_outer = v[1];
        beam_inner = v[0];
        @(posedge clk);
        sv = m_d2;
        if (rst) begin
            m_d1 = 2'b00; m_d2 = 2'b00;
            m_dir = 0; m_pos = 0; m_age = 0;
            m_entry = 1'b0; m_exit = 1'b0;
        end else begin
            m_d2 = m_d1;
            m_d1 = v;
            model_step(sv);
        end
        @(negedge clk);
        obs_q.push_back({entry_pulse, exit_pulse, busy, fault});
        exp_q.push_back({m_entry, m_exit, m_dir != 0, m_dir == 3});
    endtask

    task automatic drive(input logic [1:0] v, input int n);
        for (int k = 0; k < n; k++) tick(v);
    endtask

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        clear_q();
        rst = 1'b1;
        drive(2'b11, 3);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outputs idx=%0d got=%b want=0000", i, obs_q[i]);
            end
        end
        // Beams still blocked at release: synchronizer shows 00 first, then 11 lands in WAIT_CLR.
        clear_q();
        rst = 1'b0;
        drive(2'b11, 4);
        total++;
        if (obs_q[1] !== 4'b0000 || obs_q[2] !== 4'b0011) begin
            bad++;
            $display("FAIL reset_release_11 got=%b,%b want=0000,0011", obs_q[1], obs_q[2]);
        end
        drive(2'b00, 4);
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_model idx=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_entry();
        int t0, ne, nx, tp;
        clear_q();
        drive(2'b00, 3); drive(2'b10, 3); drive(2'b11, 3); drive(2'b01, 3);
        t0 = obs_q.size();
        drive(2'b00, 5);
        ne = 0; nx = 0; tp = -1;
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL entry_model idx=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][3]) begin ne++; tp = i; end
            if (obs_q[i][2]) nx++;
        end
        total++;
        if (ne !== 1 || nx !== 0 || tp !== t0 + 2) begin
            bad++;
            $display("FAIL entry_pulse got ne=%0d nx=%0d at=%0d want ne=1 nx=0 at=%0d", ne, nx, tp, t0 + 2);
        end
        total++;
        if (obs_q[t0+2][1] !== 1'b0 || obs_q[t0+1][1] !== 1'b1) begin
            bad++;
            $display("FAIL entry_busy_fall got=%b%b want=10", obs_q[t0+1][1], obs_q[t0+2][1]);
        end
    endtask

    task automatic test_exit();
        int ne, nx;
        clear_q();
        drive(2'b01, 3); drive(2'b11, 3); drive(2'b10, 3); drive(2'b00, 5);
        ne = 0; nx = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL exit_model idx=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][3]) ne++;
            if (obs_q[i][2]) nx++;
        end
        total++;
        if (ne !== 0 || nx !== 1) begin
            bad++;
            $display("FAIL exit_pulse got ne=%0d nx=%0d want ne=0 nx=1", ne, nx);
        end
    endtask

    task automatic test_backout();
        int np, nf;
        clear_q();
        drive(2'b10, 3); drive(2'b11, 3); drive(2'b10, 3); drive(2'b00, 5);
        np = 0; nf = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL backout_model idx=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][3] || obs_q[i][2]) np++;
            if (obs_q[i][0]) nf++;
        end
        total++;
        if (np !== 0 || nf !== 0 || obs_q[obs_q.size()-1] !== 4'b0000) begin
            bad++;
            $display("FAIL backout got pulses=%0d faults=%0d last=%b want 0 0 0000",
                     np, nf, obs_q[obs_q.size()-1]);
        end
    endtask

    task automatic test_skip();
        int np, t1, t0;
        clear_q();
        drive(2'b10, 3);
        t1 = obs_q.size();
        drive(2'b01, 3);
        t0 = obs_q.size();
        drive(2'b00, 4);
        np = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL skip_model idx=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][3] || obs_q[i][2]) np++;
        end
        total++;
        if (np !== 0 || obs_q[t1+2][0] !== 1'b1 || obs_q[t0+1][0] !== 1'b1 || obs_q[t0+2][0] !== 1'b0) begin
            bad++;
            $display("FAIL skip_fault got pulses=%0d f=%b%b%b want 0 110",
                     np, obs_q[t1+2][0], obs_q[t0+1][0], obs_q[t0+2][0]);
        end
    endtask

    task automatic test_timeout();
        int ne, nf, want_ne, want_nf;
        clear_q();
        drive(2'b10, 12); drive(2'b11, 3); drive(2'b01, 3); drive(2'b00, 5);
        ne = 0; nf = 0;
        want_ne = TO_EN ? 0 : 1;
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL timeout_model idx=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][3]) ne++;
            if (obs_q[i][0]) nf++;
        end
        want_nf = (nf > 0) ? 1 : 0;
        total++;
        if (ne !== want_ne || want_nf !== int'(TO_EN)) begin
            bad++;
            $display("FAIL timeout got ne=%0d fault_seen=%0d want ne=%0d fault_seen=%0d",
                     ne, want_nf, want_ne, TO_EN);
        end
    endtask

    task automatic test_reset_mid();
        int np, tr;
        clear_q();
        drive(2'b10, 3); drive(2'b11, 3); drive(2'b01, 3);
        drive(2'b00, 2);
        rst = 1'b1;
        tr = obs_q.size();
        drive(2'b00, 1);
        rst = 1'b0;
        drive(2'b00, 5);
        np = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_mid_model idx=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][3] || obs_q[i][2]) np++;
        end
        total++;
        if (np !== 0 || obs_q[tr] !== 4'b0000 || obs_q[tr-1][1] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid got pulses=%0d after=%b busy_before=%b want 0 0000 1",
                     np, obs_q[tr], obs_q[tr-1][1]);
        end
    endtask

    task automatic test_back_to_back();
        int ne, nx;
        clear_q();
        drive(2'b10, 2); drive(2'b11, 2); drive(2'b01, 2); drive(2'b00, 2);
        drive(2'b01, 2); drive(2'b11, 2); drive(2'b10, 2); drive(2'b00, 5);
        ne = 0; nx = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_model idx=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][3]) ne++;
            if (obs_q[i][2]) nx++;
        end
        total++;
        if (ne !== 1 || nx !== 1) begin
            bad++;
            $display("FAIL b2b_pulses got ne=%0d nx=%0d want 1 1", ne, nx);
        end
    endtask

    task automatic test_random();
        logic [1:0] walk[6];
        logic [1:0] v;
        int errs;
        walk = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b10};
        errs = 0;
        clear_q();
        for (int seg = 0; seg < 300; seg++) begin
            // Mostly follow a legal path with occasional detours so passages actually complete.
            if ($urandom_range(0, 3) != 0) v = walk[(seg % 4 == 3) ? 0 : ((seg / 4) % 2) * 3 + (seg % 4)];
            else v = 2'($urandom_range(0, 3));
            if (seg % 4 == 3) v = ($urandom_range(0, 4) == 0) ? v : 2'b00;
            rst = ($urandom_range(0, 49) == 0);
            tick(v);
            rst = 1'b0;
            drive(v, $urandom_range(0, 5));
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_model idx=%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_backout();
        test_skip();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
